// File: rtl/calc_entry_sequencer.sv
// Operand/opcode entry sequencer for the 4-bit calculator front end.
// Optional CALC_ACCUMULATE_EN: SHOW press chains the result into A.
module calc_entry_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       KEY_ENTER,
  input  logic [3:0] SW_DATA,
  input  logic [2:0] SW_OP,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic [2:0] OP,
  output logic       req_valid,
  input  logic       req_ready,
  input  logic       res_valid,
  input  logic [3:0] R_in,
  input  logic       ovf_in,
  output logic [3:0] R,
  output logic       ovf,
  output logic [2:0] stage
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    GET_A  = 3'd0,
    GET_B  = 3'd1,
    GET_OP = 3'd2,
    ISSUE  = 3'd3,
    WAIT   = 3'd4,
    SHOW   = 3'd5
  } state_e;

  logic             key_s1_q;
  logic             key_s2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             press_q;
  logic             press_d;
  state_e           state_q;
  logic [3:0]       a_q;
  logic [3:0]       b_q;
  logic [2:0]       op_q;
  logic [3:0]       r_q;
  logic             ovf_q;
  logic             req_valid_q;

  // Two-flop synchronizer; idles released (high)
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      key_s1_q <= 1'b1;
      key_s2_q <= 1'b1;
    end else begin
      key_s1_q <= KEY_ENTER;
      key_s2_q <= key_s1_q;
    end
  end

  // Debounce counter next state; press fires on the step into saturation
  always_comb begin
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (key_s2_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d   = cnt_q + 1'b1;
      press_d = (cnt_q == CNT_PRE);
    end
  end

  // Debounce state and single-cycle press pulse
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  // Entry FSM with registered operands, request and result
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= GET_A;
      a_q         <= 4'd0;
      b_q         <= 4'd0;
      op_q        <= 3'd0;
      r_q         <= 4'd0;
      ovf_q       <= 1'b0;
      req_valid_q <= 1'b0;
    end else begin
      case (state_q)
        GET_A: if (press_q) begin
          a_q     <= SW_DATA;
          state_q <= GET_B;
        end
        GET_B: if (press_q) begin
          b_q     <= SW_DATA;
          state_q <= GET_OP;
        end
        GET_OP: if (press_q) begin
          op_q        <= SW_OP;
          req_valid_q <= 1'b1;
          state_q     <= ISSUE;
        end
        ISSUE: begin
          if (req_valid_q && req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= WAIT;
          end else begin
            req_valid_q <= 1'b1;
          end
        end
        WAIT: if (res_valid) begin
          r_q     <= R_in;
          ovf_q   <= ovf_in;
          state_q <= SHOW;
        end
        SHOW: if (press_q) begin
`ifdef CALC_ACCUMULATE_EN
          if (ovf_q) begin
            state_q <= GET_A;
          end else begin
            a_q     <= r_q;
            state_q <= GET_B;
          end
`else
          state_q <= GET_A;
`endif
        end
        default: begin
          req_valid_q <= 1'b0;
          state_q     <= GET_A;
        end
      endcase
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign OP        = op_q;
  assign R         = r_q;
  assign ovf       = ovf_q;
  assign req_valid = req_valid_q;
  assign stage     = state_q;

endmodule

// File: tb/tb_calc_entry_sequencer.sv
// Directed bench for calc_entry_sequencer.
// Small debounce count keeps presses short.
module tb_calc_entry_sequencer;

  localparam int DC = 8;

  logic       clk;
  logic       rst_n;
  logic       key;
  logic [3:0] sw_data;
  logic [2:0] sw_op;
  logic [3:0] a;
  logic [3:0] b;
  logic [2:0] op;
  logic       req_valid;
  logic       req_ready;
  logic       res_valid;
  logic [3:0] r_in;
  logic       ovf_in;
  logic [3:0] r;
  logic       ovf;
  logic [2:0] stage;

  int n_vec = 0;
  int n_err = 0;

  calc_entry_sequencer #(.DEBOUNCE_CYCLES(DC)) dut (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .KEY_ENTER(key),
    .SW_DATA  (sw_data),
    .SW_OP    (sw_op),
    .A        (a),
    .B        (b),
    .OP       (op),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .res_valid(res_valid),
    .R_in     (r_in),
    .ovf_in   (ovf_in),
    .R        (r),
    .ovf      (ovf),
    .stage    (stage)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press();
    key = 1'b0;
    cyc(DC + 6);
    key = 1'b1;
    cyc(4);
  endtask

  task automatic hold_until_issue(input string tag);
    int k;
    key = 1'b0;
    k = 0;
    while (stage != 3'd3 && k < 40) begin
      cyc(1);
      k++;
    end
    chk(tag, {5'd0, stage}, 8'd3);
    key = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    key       = 1'b1;
    sw_data   = 4'd0;
    sw_op     = 3'd0;
    req_ready = 1'b0;
    res_valid = 1'b0;
    r_in      = 4'd0;
    ovf_in    = 1'b0;
    cyc(3);
    chk("rst_stage", {5'd0, stage}, 8'd0);
    chk("rst_A", {4'd0, a}, 8'd0);
    chk("rst_B", {4'd0, b}, 8'd0);
    chk("rst_OP", {5'd0, op}, 8'd0);
    chk("rst_R", {4'd0, r}, 8'd0);
    chk("rst_ovf", {7'd0, ovf}, 8'd0);
    chk("rst_rv", {7'd0, req_valid}, 8'd0);
    rst_n = 1'b1;
    cyc(2);

    // Short glitch: no press
    key = 1'b0;
    cyc(DC - 1);
    key = 1'b1;
    cyc(4);
    chk("glitch_stage", {5'd0, stage}, 8'd0);

    // Long hold gives one press only
    sw_data = 4'b0011;
    key = 1'b0;
    cyc(4 * DC);
    key = 1'b1;
    cyc(4);
    chk("a_stage", {5'd0, stage}, 8'd1);
    chk("a_val", {4'd0, a}, 8'h03);

    sw_data = 4'b1110;
    press();
    chk("b_stage", {5'd0, stage}, 8'd2);
    chk("b_val", {4'd0, b}, 8'h0e);

    sw_op = 3'd0;
    sw_data = 4'b0101;
    hold_until_issue("op_issue");
    chk("op_rv", {7'd0, req_valid}, 8'd1);
    cyc(4);

    // Stall in ISSUE with switches moving and stray inputs
    for (int i = 0; i < 5; i++) begin
      sw_data = 4'(i * 3 + 1);
      sw_op   = 3'(i + 2);
      cyc(1);
    end
    res_valid = 1'b1;
    r_in = 4'd9;
    cyc(1);
    res_valid = 1'b0;
    press();
    chk("stall_rv", {7'd0, req_valid}, 8'd1);
    chk("stall_A", {4'd0, a}, 8'h03);
    chk("stall_B", {4'd0, b}, 8'h0e);
    chk("stall_OP", {5'd0, op}, 8'd0);
    chk("stall_stage", {5'd0, stage}, 8'd3);
    chk("stall_R", {4'd0, r}, 8'd0);

    // Handshake with simultaneous res_valid: not captured
    req_ready = 1'b1;
    res_valid = 1'b1;
    r_in = 4'd5;
    cyc(1);
    req_ready = 1'b0;
    res_valid = 1'b0;
    chk("hs_stage", {5'd0, stage}, 8'd4);
    chk("hs_rv", {7'd0, req_valid}, 8'd0);
    chk("hs_R", {4'd0, r}, 8'd0);
    press();
    chk("wait_press", {5'd0, stage}, 8'd4);

    res_valid = 1'b1;
    r_in = 4'd7;
    ovf_in = 1'b1;
    cyc(1);
    res_valid = 1'b0;
    r_in = 4'd2;
    ovf_in = 1'b0;
    cyc(1);
    chk("show_stage", {5'd0, stage}, 8'd5);
    chk("show_R", {4'd0, r}, 8'h07);
    chk("show_ovf", {7'd0, ovf}, 8'd1);
    press();
    chk("ovf_ret_stage", {5'd0, stage}, 8'd0);
    chk("ovf_ret_A", {4'd0, a}, 8'h03);

    // Second pass: result without overflow
    sw_data = 4'd5;
    press();
    sw_data = 4'd2;
    press();
    sw_op = 3'd3;
    hold_until_issue("p2_issue");
    cyc(3);
    chk("p2_OP", {5'd0, op}, 8'd3);
    req_ready = 1'b1;
    cyc(1);
    req_ready = 1'b0;
    cyc(2);
    res_valid = 1'b1;
    r_in = 4'd4;
    ovf_in = 1'b0;
    cyc(1);
    res_valid = 1'b0;
    chk("p2_R", {4'd0, r}, 8'h04);
    chk("p2_ovf", {7'd0, ovf}, 8'd0);
    press();
`ifdef CALC_ACCUMULATE_EN
    chk("acc_stage", {5'd0, stage}, 8'd1);
    chk("acc_A", {4'd0, a}, 8'h04);
`else
    chk("ret_stage", {5'd0, stage}, 8'd0);
    chk("ret_A", {4'd0, a}, 8'h05);
`endif

    // Back to WAIT, then asynchronous reset
    sw_data = 4'd1;
    for (int i = 0; i < 2 && stage < 3'd2; i++) press();
    hold_until_issue("p3_issue");
    cyc(3);
    req_ready = 1'b1;
    cyc(1);
    req_ready = 1'b0;
    cyc(1);
    chk("p3_wait", {5'd0, stage}, 8'd4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_stage", {5'd0, stage}, 8'd0);
    chk("arst_A", {4'd0, a}, 8'd0);
    chk("arst_B", {4'd0, b}, 8'd0);
    chk("arst_OP", {5'd0, op}, 8'd0);
    chk("arst_R", {4'd0, r}, 8'd0);
    chk("arst_ovf", {7'd0, ovf}, 8'd0);
    chk("arst_rv", {7'd0, req_valid}, 8'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
